// File: rtl/dac_sample_packer.sv
// -----------------------------------------------------------------------------
// dac_sample_packer
//
// Packs a single-rate I/Q sample stream into 2-lane words for a
// 2-sample-per-clock DAC datapath. Consecutive samples are paired; lane 0 holds
// the earlier sample. Packed words are buffered in a small first-word-fall-
// through FIFO. A flush pulse forces out a lone held sample with lane 1 zeroed.
//
// Ports
//   clkin320    in   block clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   i_in/q_in   in   input I/Q sample (SAMPLE_W bits each)
//   in_valid    in   input sample valid
//   in_ready    out  block accepts a sample this cycle (registered-state only)
//   flush       in   1-cycle pulse: emit pending half word, lane 1 zero-padded
//   i_out/q_out out  packed head word [1:0][SAMPLE_W-1:0], zero when empty
//   out_valid   out  FIFO head word valid
//   out_ready   in   downstream accepts head word
//   fill_level  out  number of words in the FIFO
//   half_full   out  a lone sample is held waiting for its pair
// -----------------------------------------------------------------------------
module dac_sample_packer #(
    parameter int SAMPLE_W   = 14,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                 clkin320,
    input  logic                                 reset_n,
    input  logic [SAMPLE_W-1:0]                  i_in,
    input  logic [SAMPLE_W-1:0]                  q_in,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 flush,
    output logic [1:0][SAMPLE_W-1:0]             i_out,
    output logic [1:0][SAMPLE_W-1:0]             q_out,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fill_level,
    output logic                                 half_full
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WORD_W = 2 * SAMPLE_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        PH0 = 1'b0,
        PH1 = 1'b1
    } phase_t;

    // Packing state
    phase_t              phase_reg;
    logic [SAMPLE_W-1:0] hold_i_reg;
    logic [SAMPLE_W-1:0] hold_q_reg;
    logic                flush_pend_reg;

    // FIFO state
    logic [WORD_W-1:0]   mem_i [FIFO_DEPTH];
    logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;

    logic                fifo_full;
    logic                in_xfer;
    logic                pair_push;
    logic                flush_push;
    logic                push;
    logic                pop;
    logic [WORD_W-1:0]   push_i;
    logic [WORD_W-1:0]   push_q;
    logic [WORD_W-1:0]   head_i;
    logic [WORD_W-1:0]   head_q;

    assign fifo_full = (count_reg == FULL_CNT);

    // Only registered state feeds the ready/valid outputs, so neither side
    // sees a combinational path from its partner's handshake signal.
    assign in_ready  = (phase_reg == PH0) || !fifo_full;
    assign out_valid = (count_reg != '0);
    assign half_full = (phase_reg == PH1);
    assign fill_level = count_reg;

    assign in_xfer = in_valid && in_ready;

    // In PH1 in_ready already implies !fifo_full, so a pairing push never
    // lands on a full FIFO.
    assign pair_push = (phase_reg == PH1) && in_xfer;

    // A fresh flush pulse in PH1 is serviced right away when possible; one
    // that cannot be serviced yet (FIFO full, or arriving with the first
    // sample of a pair) waits in flush_pend_reg.
    assign flush_push = (phase_reg == PH1) && !in_xfer && !fifo_full &&
                        (flush_pend_reg || flush);

    assign push = pair_push || flush_push;
    assign pop  = out_valid && out_ready;

    assign push_i = pair_push ? {i_in, hold_i_reg} : {{SAMPLE_W{1'b0}}, hold_i_reg};
    assign push_q = pair_push ? {q_in, hold_q_reg} : {{SAMPLE_W{1'b0}}, hold_q_reg};

    // Packing FSM
    always_ff @(posedge clkin320 or negedge reset_n) begin
        if (!reset_n) begin
            phase_reg      <= PH0;
            hold_i_reg     <= '0;
            hold_q_reg     <= '0;
            flush_pend_reg <= 1'b0;
        end else begin
            case (phase_reg)
                PH0: begin
                    if (in_xfer) begin
                        hold_i_reg <= i_in;
                        hold_q_reg <= q_in;
                        phase_reg  <= PH1;
                        // Flush arriving with the first sample of a pair is
                        // remembered; the lone sample may still get its pair.
                        if (flush) begin
                            flush_pend_reg <= 1'b1;
                        end
                    end
                end
                PH1: begin
                    if (in_xfer) begin
                        // Pair completed: any pending flush has nothing left to do.
                        phase_reg      <= PH0;
                        flush_pend_reg <= 1'b0;
                    end else if (flush_push) begin
                        phase_reg      <= PH0;
                        flush_pend_reg <= 1'b0;
                    end else if (flush) begin
                        flush_pend_reg <= 1'b1;
                    end
                end
                default: begin
                    phase_reg <= PH0;
                end
            endcase
        end
    end

    // FIFO storage: plain array, no reset, so it maps onto distributed RAM.
    always_ff @(posedge clkin320) begin
        if (push) begin
            mem_i[wr_ptr_reg] <= push_i;
            mem_q[wr_ptr_reg] <= push_q;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap
    // naturally.
    always_ff @(posedge clkin320 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // First-word-fall-through: the head word is read asynchronously.
    assign head_i = mem_i[rd_ptr_reg];
    assign head_q = mem_q[rd_ptr_reg];

    // Lanes are forced to zero while empty so stale or uninitialised storage
    // never reaches the DAC.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign i_out[gi] = out_valid ? head_i[gi*SAMPLE_W +: SAMPLE_W] : '0;
            assign q_out[gi] = out_valid ? head_q[gi*SAMPLE_W +: SAMPLE_W] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_dac_sample_packer.sv
module tb_dac_sample_packer;

    localparam int SAMPLE_W   = 14;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int WORD_W     = 2 * SAMPLE_W;

    logic                        clk;
    logic                        reset_n;
    logic [SAMPLE_W-1:0]         i_in;
    logic [SAMPLE_W-1:0]         q_in;
    logic                        in_valid;
    logic                        in_ready;
    logic                        flush;
    logic [1:0][SAMPLE_W-1:0]    i_out;
    logic [1:0][SAMPLE_W-1:0]    q_out;
    logic                        out_valid;
    logic                        out_ready;
    logic [CNT_W-1:0]            fill_level;
    logic                        half_full;

    int total_checks;
    int passed_checks;
    int pops;

    // Scoreboard: expected packed words in FIFO order.
    logic [WORD_W-1:0] exp_i_q [$];
    logic [WORD_W-1:0] exp_q_q [$];

    // Reference packer model
    int                  m_phase;
    logic [SAMPLE_W-1:0] m_hold_i;
    logic [SAMPLE_W-1:0] m_hold_q;

    dac_sample_packer #(
        .SAMPLE_W   (SAMPLE_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clkin320   (clk),
        .reset_n    (reset_n),
        .i_in       (i_in),
        .q_in       (q_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .i_out      (i_out),
        .q_out      (q_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_level (fill_level),
        .half_full  (half_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Output monitor: inputs change #1 after posedge, so at negedge the
    // handshake is stable and a pop will occur on the next rising edge.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            logic [WORD_W-1:0] ei;
            logic [WORD_W-1:0] eq;
            total_checks++;
            pops++;
            if (exp_i_q.size() == 0) begin
                $display("FAIL word_unexpected: got i=%h q=%h, required no word", i_out, q_out);
            end else begin
                ei = exp_i_q.pop_front();
                eq = exp_q_q.pop_front();
                if (i_out !== ei || q_out !== eq)
                    $display("FAIL word_data: got i=%h q=%h, required i=%h q=%h", i_out, q_out, ei, eq);
                else
                    passed_checks++;
                $display("word %0d: i=%h q=%h", pops, i_out, q_out);
            end
        end
    end

    task automatic model_reset();
        m_phase = 0;
        m_hold_i = '0;
        m_hold_q = '0;
        exp_i_q.delete();
        exp_q_q.delete();
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        i_in      = '0;
        q_in      = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Drive one sample until accepted; optional flush pulse on the accept cycle.
    task automatic send(input logic [SAMPLE_W-1:0] si, input logic [SAMPLE_W-1:0] sq,
                        input logic with_flush);
        logic rdy;
        logic done;
        done = 1'b0;
        in_valid = 1'b1;
        i_in = si;
        q_in = sq;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            rdy = in_ready;
            flush = with_flush && rdy;
            @(posedge clk);
            #1;
            flush = 1'b0;
            if (rdy) begin
                done = 1'b1;
                if (m_phase == 0) begin
                    m_hold_i = si;
                    m_hold_q = sq;
                    m_phase = 1;
                end else begin
                    exp_i_q.push_back({si, m_hold_i});
                    exp_q_q.push_back({sq, m_hold_q});
                    m_phase = 0;
                end
                $display("in: i=%h q=%h", si, sq);
            end
        end
        if (!done) begin
            total_checks++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles, required acceptance");
        end
    endtask

    task automatic wait_empty();
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(posedge clk);
            #1;
            if (fill_level == 0 && exp_i_q.size() == 0) ok = 1'b1;
        end
        total_checks++;
        if (!ok)
            $display("FAIL drain: got fill_level=%0d pending=%0d, required 0/0", fill_level, exp_i_q.size());
        else
            passed_checks++;
    endtask

    task automatic test_reset();
        do_reset();
        total_checks++;
        if (out_valid !== 1'b0 || fill_level !== 0 || half_full !== 1'b0 || in_ready !== 1'b1 ||
            i_out !== '0 || q_out !== '0)
            $display("FAIL reset_state: got ov=%b fl=%0d hf=%b ir=%b i=%h q=%h, required 0 0 0 1 0 0",
                     out_valid, fill_level, half_full, in_ready, i_out, q_out);
        else
            passed_checks++;
    endtask

    task automatic test_basic_pack();
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            logic [SAMPLE_W-1:0] si;
            logic [SAMPLE_W-1:0] sq;
            si = SAMPLE_W'(k);
            sq = SAMPLE_W'(-k);
            send(si, sq, 1'b0);
            total_checks++;
            if (out_valid !== ((k % 2) == 0))
                $display("FAIL pack_valid_%0d: got out_valid=%b, required %b", k, out_valid, (k % 2) == 0);
            else
                passed_checks++;
        end
        in_valid = 1'b0;
        wait_empty();
    endtask

    task automatic test_fill_and_drain();
        int pops0;
        do_reset();
        for (int k = 0; k < 2 * FIFO_DEPTH + 1; k++)
            send(SAMPLE_W'(16 + k), SAMPLE_W'(100 + 3 * k), 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        total_checks++;
        if (fill_level !== CNT_W'(FIFO_DEPTH) || half_full !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL full_state: got fl=%0d hf=%b ir=%b, required %0d 1 0",
                     fill_level, half_full, in_ready, FIFO_DEPTH);
        else
            passed_checks++;
        pops0 = pops;
        out_ready = 1'b1;
        wait_empty();
        total_checks++;
        if (pops - pops0 != FIFO_DEPTH)
            $display("FAIL drain_count: got %0d words, required %0d", pops - pops0, FIFO_DEPTH);
        else
            passed_checks++;
    endtask

    task automatic test_flush_single();
        int pops0;
        do_reset();
        out_ready = 1'b1;
        // Flush with nothing held must not create a word.
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_checks++;
        if (pops != 0 && fill_level !== 0 || fill_level !== 0 || half_full !== 1'b0)
            $display("FAIL flush_idle: got fl=%0d hf=%b, required 0 0", fill_level, half_full);
        else
            passed_checks++;
        pops0 = pops;
        send(14'h1FFF, 14'h2AAA, 1'b0);
        in_valid = 1'b0;
        total_checks++;
        if (half_full !== 1'b1)
            $display("FAIL flush_held: got half_full=%b, required 1", half_full);
        else
            passed_checks++;
        flush = 1'b1;
        exp_i_q.push_back({{SAMPLE_W{1'b0}}, m_hold_i});
        exp_q_q.push_back({{SAMPLE_W{1'b0}}, m_hold_q});
        m_phase = 0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_empty();
        total_checks++;
        if (half_full !== 1'b0 || pops - pops0 != 1)
            $display("FAIL flush_done: got hf=%b words=%0d, required 0 1", half_full, pops - pops0);
        else
            passed_checks++;
    endtask

    task automatic test_flush_with_pair();
        int pops0;
        do_reset();
        out_ready = 1'b1;
        pops0 = pops;
        send(14'h0123, 14'h3210, 1'b1);
        send(14'h0456, 14'h3654, 1'b0);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        wait_empty();
        total_checks++;
        if (pops - pops0 != 1 || half_full !== 1'b0)
            $display("FAIL flush_pair: got words=%0d hf=%b, required 1 0", pops - pops0, half_full);
        else
            passed_checks++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 2 * FIFO_DEPTH + 1; k++)
            send(SAMPLE_W'($urandom), SAMPLE_W'($urandom), 1'b0);
        total_checks++;
        if (in_ready !== 1'b0 || fill_level !== CNT_W'(FIFO_DEPTH))
            $display("FAIL b2b_full: got ir=%b fl=%0d, required 0 %0d", in_ready, fill_level, FIFO_DEPTH);
        else
            passed_checks++;
        // Pop and push on the same edge: level must not move.
        out_ready = 1'b1;
        send(SAMPLE_W'($urandom), SAMPLE_W'($urandom), 1'b0);
        total_checks++;
        if (fill_level !== CNT_W'(FIFO_DEPTH - 1))
            $display("FAIL b2b_level: got fl=%0d, required %0d", fill_level, FIFO_DEPTH - 1);
        else
            passed_checks++;
        out_ready = 1'b0;
        send(SAMPLE_W'($urandom), SAMPLE_W'($urandom), 1'b0);
        send(SAMPLE_W'($urandom), SAMPLE_W'($urandom), 1'b0);
        in_valid = 1'b0;
        total_checks++;
        if (fill_level !== CNT_W'(FIFO_DEPTH))
            $display("FAIL b2b_refill: got fl=%0d, required %0d", fill_level, FIFO_DEPTH);
        else
            passed_checks++;
        out_ready = 1'b1;
        wait_empty();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 7; k++)
            send(SAMPLE_W'(k + 1), SAMPLE_W'(k + 40), 1'b0);
        in_valid = 1'b0;
        total_checks++;
        if (fill_level !== 3 || half_full !== 1'b1)
            $display("FAIL pre_reset: got fl=%0d hf=%b, required 3 1", fill_level, half_full);
        else
            passed_checks++;
        #1;
        reset_n = 1'b0;
        #1;
        total_checks++;
        if (out_valid !== 1'b0 || fill_level !== 0 || half_full !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL async_reset: got ov=%b fl=%0d hf=%b ir=%b, required 0 0 0 1",
                     out_valid, fill_level, half_full, in_ready);
        else
            passed_checks++;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        pops          = 0;
        reset_n       = 1'b1;
        in_valid      = 1'b0;
        flush         = 1'b0;
        out_ready     = 1'b0;
        i_in          = '0;
        q_in          = '0;
        test_reset();
        test_basic_pack();
        test_fill_and_drain();
        test_flush_single();
        test_flush_with_pair();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
